// File: rtl/stbus_pkg.sv
// Shared types and frame geometry for the ST-bus frame scheduler.
package stbus_pkg;
  localparam int FRAME_LEN   = 512;
  localparam int C4_PER_BIT  = 2;
  localparam int BITS_PER_TS = 8;
  localparam int CNT_W       = $clog2(FRAME_LEN);
  localparam int NUM_CH      = 2;

  typedef logic [4:0]       ts_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED,
    FLYWHEEL
  } state_t;
endpackage

// File: rtl/stbus_ts_gate.sv
// Per-channel timeslot gate: frame-aligned shadow of the slot selection and
// the registered bit strobe for that slot.
module stbus_ts_gate
  import stbus_pkg::*;
(
  input  logic       c4,
  input  logic       rst,
  input  logic       load,      // frame boundary (or hunting): take new selection
  input  logic [4:0] sel_in,
  input  logic       on_in,
  input  logic [4:0] slot,      // current timeslot
  input  logic       even,      // current c4 is the first half of a bit
  input  logic       lock,
  input  logic       suppress,  // lost arbitration for this frame
  output logic [4:0] sh_sel,
  output logic       sh_on,
  output logic       strobe
);
  // Strobe is computed one cycle early (on the even half) so it lands on the
  // odd half of each bit; lock and shadows cannot change across an even edge.
  always_ff @(posedge c4 or posedge rst) begin
    if (rst) begin
      sh_sel <= '0;
      sh_on  <= 1'b0;
      strobe <= 1'b0;
    end else begin
      if (load) begin
        sh_sel <= sel_in;
        sh_on  <= on_in;
      end
      strobe <= lock & even & sh_on & ~suppress & (slot == sh_sel);
    end
  end
endmodule

// File: rtl/stbus_frame_sched.sv
// ST-bus frame-sync controller: f0 edge detect, bit/timeslot counter,
// HUNT/VERIFY/LOCKED/FLYWHEEL lock FSM and two-channel strobe arbitration.
module stbus_frame_sched
  import stbus_pkg::*;
#(
  parameter int NUM_TS        = 32,
  parameter int VERIFY_FRAMES = 2,
  parameter int MISS_LIMIT    = 3
) (
  input  logic       c4,
  input  logic       rst,
  input  logic       f0,
  input  logic [4:0] ts1_sel,
  input  logic       ts1_on,
  input  logic [4:0] ts2_sel,
  input  logic       ts2_on,
  output logic       clk_en1,
  output logic       clk_en2,
  output logic [4:0] ts_num,
  output logic [2:0] bit_num,
  output logic       frame_start,
  output logic       lock,
  output logic       sync_err,
  output logic       conflict
);
  localparam cnt_t       CNT_LAST = cnt_t'(NUM_TS * BITS_PER_TS * C4_PER_BIT - 1);
  localparam logic [3:0] VF       = 4'(VERIFY_FRAMES);
  localparam logic [3:0] ML       = 4'(MISS_LIMIT);

  state_t     state;
  cnt_t       cnt;
  logic [3:0] vcnt, miss;
  logic       f0_q, fall, at_end, load;

  logic [NUM_CH-1:0][4:0] sel_in, sh_sel;
  logic [NUM_CH-1:0]      on_in, sh_on, suppress, strobe;

  // f0 is active low; only the high->low transition counts, so a long pulse is one event
  assign fall   = f0_q & ~f0;
  assign at_end = (cnt == CNT_LAST);

  assign ts_num      = cnt[8:4];
  assign bit_num     = cnt[3:1];
  assign lock        = (state == LOCKED) || (state == FLYWHEEL);
  assign frame_start = (cnt == '0) && (state != HUNT);

  // Lock FSM with frame counter; misplaced pulses only realign while verifying
  always_ff @(posedge c4 or posedge rst) begin
    if (rst) begin
      state    <= HUNT;
      cnt      <= '0;
      vcnt     <= '0;
      miss     <= '0;
      f0_q     <= 1'b1;
      sync_err <= 1'b0;
    end else begin
      f0_q     <= f0;
      sync_err <= 1'b0;
      cnt      <= at_end ? '0 : cnt + 1'b1;
      case (state)
        HUNT:
          if (fall) begin
            cnt   <= '0;
            vcnt  <= '0;
            state <= VERIFY;
          end
        VERIFY:
          if (at_end) begin
            if (fall) begin
              vcnt <= vcnt + 4'd1;
              if (vcnt + 4'd1 == VF) state <= LOCKED;
            end else begin
              state    <= HUNT;
              sync_err <= 1'b1;
            end
          end else if (fall) begin
            cnt      <= '0;
            vcnt     <= '0;
            sync_err <= 1'b1;
          end
        LOCKED:
          if (at_end && !fall) begin
            state    <= FLYWHEEL;
            miss     <= 4'd1;
            sync_err <= 1'b1;
          end else if (!at_end && fall) begin
            sync_err <= 1'b1;
          end
        FLYWHEEL:
          if (at_end) begin
            if (fall) begin
              state <= LOCKED;
              miss  <= '0;
            end else begin
              miss     <= miss + 4'd1;
              sync_err <= 1'b1;
              if (miss + 4'd1 == ML) state <= HUNT;
            end
          end else if (fall) begin
            sync_err <= 1'b1;
          end
        default: state <= HUNT;
      endcase
    end
  end

  // Selections track inputs while hunting, otherwise freeze at the frame boundary
  assign load     = at_end || (state == HUNT);
  assign sel_in   = {ts2_sel, ts1_sel};
  assign on_in    = {ts2_on, ts1_on};
  // ch1 wins a shared slot; shadows are frame-stable so ch2 loses the whole frame
  assign conflict = sh_on[0] & sh_on[1] & (sh_sel[0] == sh_sel[1]);
  assign suppress = {conflict, 1'b0};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    stbus_ts_gate u_gate (
      .c4      (c4),
      .rst     (rst),
      .load    (load),
      .sel_in  (sel_in[i]),
      .on_in   (on_in[i]),
      .slot    (cnt[8:4]),
      .even    (~cnt[0]),
      .lock    (lock),
      .suppress(suppress[i]),
      .sh_sel  (sh_sel[i]),
      .sh_on   (sh_on[i]),
      .strobe  (strobe[i])
    );
  end

  assign clk_en1 = strobe[0];
  assign clk_en2 = strobe[1];
endmodule

// File: tb/tb_stbus_frame_sched.sv
// Scoreboard bench for stbus_frame_sched: stimulus pushes expected events
// (cycle-stamped), a negedge monitor matches every observed event against them.
`timescale 1ns/1ps
module tb_stbus_frame_sched;
  localparam int K_LUP = 0, K_LDN = 1, K_FS = 2, K_ERR = 3;
  localparam int K_EN1 = 4, K_EN2 = 5, K_CUP = 6, K_CDN = 7;

  typedef struct {
    int kind;
    int cyc;
    int ts;
    int bt;
  } ev_t;

  ev_t   exp_q[$];
  string kname[8] = '{"lock_rise", "lock_fall", "frame_start", "sync_err",
                      "clk_en1", "clk_en2", "conflict_rise", "conflict_fall"};

  logic       c4 = 1'b0, rst = 1'b0, f0 = 1'b1;
  logic [4:0] ts1_sel = 5'd5, ts2_sel = 5'd0;
  logic       ts1_on = 1'b1, ts2_on = 1'b0;
  logic       clk_en1, clk_en2, frame_start, lock, sync_err, conflict;
  logic [4:0] ts_num;
  logic [2:0] bit_num;

  int   cyc = 0, n_tests = 0, n_fail = 0;
  logic lock_p = 1'b0, cf_p = 1'b0;

  // mid-frame input change applied by the frame driver
  logic       mid_en = 1'b0;
  logic [4:0] mid_ts1_sel = '0, mid_ts2_sel = '0;
  logic       mid_ts2_on = 1'b0;

  stbus_frame_sched dut (
    .c4(c4), .rst(rst), .f0(f0),
    .ts1_sel(ts1_sel), .ts1_on(ts1_on), .ts2_sel(ts2_sel), .ts2_on(ts2_on),
    .clk_en1(clk_en1), .clk_en2(clk_en2), .ts_num(ts_num), .bit_num(bit_num),
    .frame_start(frame_start), .lock(lock), .sync_err(sync_err), .conflict(conflict)
  );

  always #5 c4 = ~c4;
  always @(posedge c4) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push(input int kind, input int c, input int ts = 0, input int bt = 0);
    ev_t e;
    e.kind = kind; e.cyc = c; e.ts = ts; e.bt = bt;
    exp_q.push_back(e);
  endtask

  // 8 strobes of one slot: cnt = slot*16 + 1, +3, ... +15 relative to frame start
  task automatic exp_slot(input int kind, input int base, input int s);
    for (int b = 0; b < 8; b++) push(kind, base + s * 16 + 1 + 2 * b, s, b);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " clk_en1"}, int'(clk_en1), 0);
    chk({tag, " clk_en2"}, int'(clk_en2), 0);
    chk({tag, " lock"}, int'(lock), 0);
    chk({tag, " frame_start"}, int'(frame_start), 0);
    chk({tag, " sync_err"}, int'(sync_err), 0);
    chk({tag, " conflict"}, int'(conflict), 0);
    chk({tag, " ts_num"}, int'(ts_num), 0);
    chk({tag, " bit_num"}, int'(bit_num), 0);
  endtask

  // Drive len c4 periods from a negedge; f0 low for 'width' periods at the start
  task automatic frame(input bit pulse, input int width, input int len);
    for (int i = 0; i < len; i++) begin
      f0 = (pulse && i < width) ? 1'b0 : 1'b1;
      if (mid_en && i == 100) begin
        ts1_sel = mid_ts1_sel;
        ts2_sel = mid_ts2_sel;
        ts2_on  = mid_ts2_on;
        mid_en  = 1'b0;
      end
      @(negedge c4);
    end
  endtask

  task automatic observe(input int kind);
    int idx = -1;
    n_tests++;
    foreach (exp_q[j])
      if (idx < 0 && exp_q[j].kind == kind && exp_q[j].cyc == cyc) idx = j;
    if (idx < 0) begin
      n_fail++;
      $display("FAIL %s: seen at cycle %0d, none expected", kname[kind], cyc);
    end else begin
      if (kind == K_EN1 || kind == K_EN2) begin
        n_tests++;
        if (int'(ts_num) != exp_q[idx].ts || int'(bit_num) != exp_q[idx].bt) begin
          n_fail++;
          $display("FAIL %s position: cycle %0d ts/bit %0d/%0d, want %0d/%0d", kname[kind],
                   cyc, ts_num, bit_num, exp_q[idx].ts, exp_q[idx].bt);
        end
      end
      exp_q.delete(idx);
    end
  endtask

  // Monitor: match every output event, then flag expectations now overdue
  always @(negedge c4) begin
    if (lock && !lock_p) observe(K_LUP);
    if (!lock && lock_p) observe(K_LDN);
    if (frame_start) observe(K_FS);
    if (sync_err) observe(K_ERR);
    if (clk_en1) observe(K_EN1);
    if (clk_en2) observe(K_EN2);
    if (conflict && !cf_p) observe(K_CUP);
    if (!conflict && cf_p) observe(K_CDN);
    lock_p = lock;
    cf_p   = conflict;
    for (int j = exp_q.size() - 1; j >= 0; j--) begin
      if (exp_q[j].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: expected at cycle %0d, not seen by %0d", kname[exp_q[j].kind],
                 exp_q[j].cyc, cyc);
        exp_q.delete(j);
      end
    end
  end

  initial begin
    int p;
    #1 rst = 1'b1;
    repeat (3) @(negedge c4);
    check_idle("reset");
    rst = 1'b0;
    repeat (3) @(negedge c4);

    // acquire: lock on the 3rd good pulse, ch1 slot 5 strobes once locked
    p = cyc + 1; push(K_FS, p); frame(1, 1, 512);
    p = cyc + 1; push(K_FS, p); frame(1, 1, 512);
    p = cyc + 1; push(K_LUP, p); push(K_FS, p); exp_slot(K_EN1, p, 5); frame(1, 1, 512);
    // 2-cycle-wide pulse is still one edge
    p = cyc + 1; push(K_FS, p); exp_slot(K_EN1, p, 5); frame(1, 2, 512);

    // two misses ride the flywheel, then recover
    for (int k = 0; k < 2; k++) begin
      p = cyc + 1; push(K_FS, p); push(K_ERR, p); exp_slot(K_EN1, p, 5); frame(0, 0, 512);
    end
    p = cyc + 1; push(K_FS, p); exp_slot(K_EN1, p, 5); frame(1, 1, 512);

    // three misses drop to HUNT
    for (int k = 0; k < 2; k++) begin
      p = cyc + 1; push(K_FS, p); push(K_ERR, p); exp_slot(K_EN1, p, 5); frame(0, 0, 512);
    end
    p = cyc + 1; push(K_ERR, p); push(K_LDN, p); frame(0, 0, 512);

    // relock; mid-frame request both channels on slot 7
    p = cyc + 1; push(K_FS, p); frame(1, 1, 512);
    p = cyc + 1; push(K_FS, p); frame(1, 1, 512);
    p = cyc + 1; push(K_LUP, p); push(K_FS, p); exp_slot(K_EN1, p, 5);
    mid_ts1_sel = 5'd7; mid_ts2_sel = 5'd7; mid_ts2_on = 1'b1; mid_en = 1'b1;
    frame(1, 1, 512);
    // conflict frame: ch1 only; move ch2 to slot 9 mid-frame
    p = cyc + 1; push(K_FS, p); push(K_CUP, p); exp_slot(K_EN1, p, 7);
    mid_ts1_sel = 5'd7; mid_ts2_sel = 5'd9; mid_ts2_on = 1'b1; mid_en = 1'b1;
    frame(1, 1, 512);
    p = cyc + 1; push(K_FS, p); push(K_CDN, p); exp_slot(K_EN1, p, 7); exp_slot(K_EN2, p, 9);
    frame(1, 1, 512);

    // async reset inside the first strobe of slot 7 (cnt 113)
    p = cyc + 1; push(K_FS, p); push(K_LDN, p + 113);
    f0 = 1'b0;
    @(negedge c4);
    f0 = 1'b1;
    repeat (112) @(negedge c4);
    @(posedge c4);
    #2 rst = 1'b1;
    #1 check_idle("async reset");
    repeat (3) @(negedge c4);
    rst = 1'b0;
    repeat (2) @(negedge c4);

    // VERIFY with a pulse at cnt 300: error, realign, lock after 2 more good frames
    p = cyc + 1; push(K_FS, p); frame(1, 1, 301);
    p = cyc + 1; push(K_ERR, p); push(K_FS, p); frame(1, 1, 512);
    p = cyc + 1; push(K_FS, p); frame(1, 1, 512);
    p = cyc + 1; push(K_LUP, p); push(K_FS, p); exp_slot(K_EN1, p, 7); exp_slot(K_EN2, p, 9);
    frame(1, 1, 512);
    p = cyc + 1; push(K_FS, p); exp_slot(K_EN1, p, 7); exp_slot(K_EN2, p, 9);
    frame(1, 1, 512);

    #1;
    foreach (exp_q[j]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: expected at cycle %0d, never seen", kname[exp_q[j].kind], exp_q[j].cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
